sram_100_qsys_cpu_jtag_sysclk_bridge: RTL
=========================================

// Module: sram_100_qsys_cpu_jtag_sysclk_bridge
// PURPOSE
//  Parametrised successor to the fixed-width Nios II debug sysclk stage.
//  Receives the tck-domain shift register (sr), IR and update strobes (vs_uir/vs_udr).
//  Synchronises the strobes into clk and captures sr into jdo.
//  Decodes one take_action/take_no_action pulse per IR channel.
//  Optional HOLD mode keeps the action asserted until the core accepts it.
//  Flags overruns when a new update arrives before the previous one is consumed.
// PARAMETERS
//  SR_W        38  width of sr/jdo; jdo[SR_W-1] is the action bit
//  IR_W        2   width of ir_in; number of channels N_CH = 2**IR_W
//  SYNC_STAGES 2   synchroniser flops per strobe (legal range 2..4)
//  HOLD_MODE   0   0: single-cycle action pulse; 1: hold until act_ready
//  OVR_CNT_W   8   width of the saturating overrun counter
// PORTS
//  clk           in   1        system clock
//  reset_n       in   1        asynchronous active-low reset
//  sr            in   SR_W     tck-domain shift register; stable while vs_udr is high
//  ir_in         in   IR_W     tck-domain IR; stable while vs_uir is high
//  vs_uir        in   1        update-IR level from tck domain (async)
//  vs_udr        in   1        update-DR level from tck domain (async)
//  act_ready     in   1        core accepts the current action (used only when HOLD_MODE=1)
//  ovr_clear     in   1        clears ovr_sticky and ovr_cnt
//  jdo           out  SR_W     captured data word
//  ir_q          out  IR_W     captured IR
//  take_action   out  N_CH     one-hot action strobe (jdo[SR_W-1]=1)
//  take_no_action out N_CH     one-hot strobe (jdo[SR_W-1]=0)
//  busy          out  1        state != IDLE
//  ovr_sticky    out  1        an update was dropped since the last clear
//  ovr_cnt       out  OVR_CNT_W count of dropped updates, saturating
// BEHAVIOUR
//  Reset values: every output is 0 and the state is IDLE. Reset takes effect asynchronously, including mid-action.
//  Synchroniser: each of vs_uir and vs_udr passes through SYNC_STAGES flops plus one history flop.
//  The rising edge of each synchronised strobe gives one-cycle pulses uir_p and udr_p. Levels never retrigger.
//  E0 is the first clk edge that samples the strobe high.
//  uir_p: ir_q <= ir_in at edge E0+SYNC_STAGES, in any state.
//  udr_p in IDLE: at edge E0+SYNC_STAGES, jdo <= sr and state moves to ISSUE.
//   In the same cycle, exactly one bit of take_action or take_no_action asserts, at index ir_q.
//   All outputs are registered.
//  uir_p and udr_p in the same cycle: the decode uses the new ir_in value, not the old ir_q.
//  States:
//   IDLE: waits for udr_p.
//   ISSUE:
//    HOLD_MODE=0: strobe lasts exactly one cycle, then IDLE.
//    HOLD_MODE=1: strobe is held until a cycle with act_ready=1. It deasserts and the state returns to IDLE on the next edge.
//    act_ready=1 in the very first ISSUE cycle gives a one-cycle strobe.
//  udr_p while busy: the update is dropped. jdo is unchanged and no strobe is issued.
//   ovr_sticky <= 1 and ovr_cnt increments, saturating at all-ones.
//  udr_p in the cycle that returns to IDLE also counts as busy, so it is dropped.
//  ovr_clear and a simultaneous overrun: the overrun wins (sticky=1, cnt=1).
//  The sr/ir_in capture is a declared multicycle path. Data is stable for at least SYNC_STAGES+1 clk cycles after the strobe.
//  Widths: take_* is N_CH wide. The strobe index is the unsigned ir_q value. No other arithmetic.
// STRUCTURE
//  Package sram_100_qsys_jtag_dbg_pkg holds:
//   state enum {IDLE, ISSUE}
//   IR channel constants (IR_OCIMEM=0, IR_TRACEMEM=1, IR_BREAK=2, IR_TRACECTRL=3)
//   localparam N_CH
//  Sub-module sram_100_qsys_sync_pulse (param STAGES): async level in -> synchronised level and rise pulse.
//   Instantiated twice, once each for vs_uir and vs_udr.
// TESTING
//  1 Reset mid-action: assert reset_n=0 during ISSUE -> all outputs 0 asynchronously, no strobe after release.
//  2 Basic decode, SYNC_STAGES=2, HOLD_MODE=0:
//    stimulus: ir_in=2, vs_uir pulse, sr=38'h20_0000_00AB, vs_udr high at E0
//    response: jdo=38'h20_0000_00AB and take_action=4'b0100 for exactly one cycle starting at E0+2. take_no_action stays 0.
//  3 No-action path: ir_in=1, sr[37]=0 -> take_no_action=4'b0010 for one cycle. take_action stays 0.
//  4 HOLD_MODE=1: act_ready held low for 5 cycles, then high for 1 cycle.
//    response: strobe stays high for 6 cycles; busy falls on the next edge.
//  5 Overrun: a second vs_udr while HOLD_MODE=1 is waiting.
//    response: ovr_sticky=1, ovr_cnt=1, jdo unchanged.
//    Then 300 overruns with OVR_CNT_W=8 -> ovr_cnt=255. ovr_clear -> ovr_sticky=0, ovr_cnt=0.
//  6 Coincident strobes: vs_uir and vs_udr rise at the same edge with ir_in=3 (old ir_q=0).
//    response: take_action=4'b1000 and ir_q=3.

Source files
------------

// File: rtl/sram_100_qsys_jtag_dbg_pkg.sv
// Shared types and constants for the Nios II JTAG debug sysclk bridge.
// Channel numbering follows the debug module's IR encoding.
package sram_100_qsys_jtag_dbg_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } dbg_state_e;

   localparam int IR_W_DFLT = 2;
   localparam int N_CH      = 2 ** IR_W_DFLT;

   localparam int unsigned IR_OCIMEM    = 0;
   localparam int unsigned IR_TRACEMEM  = 1;
   localparam int unsigned IR_BREAK     = 2;
   localparam int unsigned IR_TRACECTRL = 3;

endpackage

// File: rtl/sram_100_qsys_sync_pulse.sv
// Multi-flop synchroniser for an asynchronous level, with a one-cycle
// pulse on each rising edge of the synchronised level.
module sram_100_qsys_sync_pulse #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic rise
);

   logic [STAGES-1:0] sync_q;
   logic              hist_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         sync_q <= {sync_q[STAGES-2:0], async_in};
         hist_q <= sync_q[STAGES-1];
      end
   end

   assign rise = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/sram_100_qsys_cpu_jtag_sysclk_bridge.sv
// Brings tck-domain update strobes into clk, captures sr/ir, and issues one
// take_action / take_no_action strobe per update, counting dropped updates.
module sram_100_qsys_cpu_jtag_sysclk_bridge
   import sram_100_qsys_jtag_dbg_pkg::*;
#(
   parameter int SR_W        = 38,
   parameter int IR_W        = IR_W_DFLT,
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_MODE   = 0,
   parameter int OVR_CNT_W   = 8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [SR_W-1:0]        sr,
   input  logic [IR_W-1:0]        ir_in,
   input  logic                   vs_uir,
   input  logic                   vs_udr,
   input  logic                   act_ready,
   input  logic                   ovr_clear,
   output logic [SR_W-1:0]        jdo,
   output logic [IR_W-1:0]        ir_q,
   output logic [(2**IR_W)-1:0]   take_action,
   output logic [(2**IR_W)-1:0]   take_no_action,
   output logic                   busy,
   output logic                   ovr_sticky,
   output logic [OVR_CNT_W-1:0]   ovr_cnt
);

   localparam int CH = 2 ** IR_W;

   logic uir_p;
   logic udr_p;

   sram_100_qsys_sync_pulse #(.STAGES(SYNC_STAGES)) u_sync_uir (
      .clk      (clk),
      .rst_n    (reset_n),
      .async_in (vs_uir),
      .rise     (uir_p)
   );

   sram_100_qsys_sync_pulse #(.STAGES(SYNC_STAGES)) u_sync_udr (
      .clk      (clk),
      .rst_n    (reset_n),
      .async_in (vs_udr),
      .rise     (udr_p)
   );

   dbg_state_e             state, state_n;
   logic [SR_W-1:0]        jdo_n;
   logic [IR_W-1:0]        ir_n;
   logic [CH-1:0]          act_n, noact_n, onehot;
   logic                   ovr_n, overrun;
   logic [OVR_CNT_W-1:0]   cnt_n;

   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      state_n = state;
      jdo_n   = jdo;
      ir_n    = uir_p ? ir_in : ir_q;   // a coincident IR update steers this decode
      act_n   = take_action;
      noact_n = take_no_action;
      ovr_n   = ovr_sticky;
      cnt_n   = ovr_cnt;
      overrun = 1'b0;
      onehot  = '0;
      onehot[ir_n] = 1'b1;

      case (state)
         IDLE: begin
            if (udr_p) begin
               state_n = ISSUE;
               jdo_n   = sr;
               if (sr[SR_W-1]) act_n   = onehot;
               else            noact_n = onehot;
            end
         end
         ISSUE: begin
            overrun = udr_p;   // includes the cycle that hands back to IDLE
            if (HOLD_MODE == 0 || act_ready) begin
               state_n = IDLE;
               act_n   = '0;
               noact_n = '0;
            end
         end
         default: state_n = IDLE;
      endcase

      if (overrun) begin
         ovr_n = 1'b1;
         if (ovr_clear)            cnt_n = OVR_CNT_W'(1);
         else if (ovr_cnt != '1)   cnt_n = ovr_cnt + OVR_CNT_W'(1);
      end else if (ovr_clear) begin
         ovr_n = 1'b0;
         cnt_n = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         jdo            <= '0;
         ir_q           <= '0;
         take_action    <= '0;
         take_no_action <= '0;
         ovr_sticky     <= 1'b0;
         ovr_cnt        <= '0;
      end else begin
         state          <= state_n;
         jdo            <= jdo_n;
         ir_q           <= ir_n;
         take_action    <= act_n;
         take_no_action <= noact_n;
         ovr_sticky     <= ovr_n;
         ovr_cnt        <= cnt_n;
      end
   end

   assign busy = (state != IDLE);

endmodule
